// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and
// elaboration-time width helpers.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_DONE     = 2'd2,
    S_ERROR    = 2'd3
  } seq_state_e;

  // Number of bits needed to hold values 0..value-1 (0 for value<=1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES downstream resets one at a time in index order.
// Stage 0 is released after a hold delay; each later stage is released when
// the previous stage acknowledges. A missing ack within ACK_TIMEOUT cycles
// pulls every stage back into reset and latches the failing stage index.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255,
  localparam int IDX_W      = max2(1, clog2(NUM_STAGES))
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  sw_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ack,
  output logic [NUM_STAGES-1:0] stage_reset_n,
  output logic                  seq_done,
  output logic                  seq_error,
  output logic [IDX_W-1:0]      err_stage
);

  // One counter serves both the hold delay and the ack timeout.
  localparam int CNT_W = clog2(max2(HOLD_CYCLES, ACK_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam bit               TIMEOUT_EN   = (ACK_TIMEOUT != 0);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  seq_state_e       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // Sequencing FSM; every output is a flop updated here.
  always_ff @(posedge clk) begin
    // NOTE: sync_reset and sw_reset_req share one branch because both force
    // the identical restart; the reset branch is tested first so it wins over
    // any state activity, and all state uses <= so every flop sees pre-edge values.
    if (sync_reset || sw_reset_req) begin
      state         <= S_HOLD;
      idx           <= '0;
      cnt           <= '0;
      stage_reset_n <= '0;
      seq_done      <= 1'b0;
      seq_error     <= 1'b0;
      err_stage     <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            stage_reset_n <= NUM_STAGES'(1);
            idx           <= '0;
            cnt           <= '0;
            state         <= S_WAIT_ACK;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WAIT_ACK: begin
          // Only the current stage's ack matters; the ack beats a same-edge timeout.
          if (stage_ack[idx]) begin
            if (idx == LAST_IDX) begin
              seq_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              stage_reset_n <= stage_reset_n | (NUM_STAGES'(1) << (idx + IDX_W'(1)));
              idx           <= idx + IDX_W'(1);
              cnt           <= '0;
            end
          end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
            seq_error     <= 1'b1;
            err_stage     <= idx;
            stage_reset_n <= '0;
            state         <= S_ERROR;
          end else if (cnt != '1) begin
            // Saturate so a disabled timeout never lets the counter wrap.
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_DONE, S_ERROR: begin
          // Terminal until a restart request or sync_reset.
        end

        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (NUM_STAGES=4, HOLD_CYCLES=16).
// dut uses ACK_TIMEOUT=8; dut_nt uses ACK_TIMEOUT=0 with its acks held low.
module tb_reset_sequencer;

  logic       clk;
  logic       sync_reset;
  logic       sw_reset_req;
  logic [3:0] stage_ack;
  logic [3:0] stage_reset_n;
  logic       seq_done;
  logic       seq_error;
  logic [1:0] err_stage;

  logic       nt_sync_reset;
  logic       nt_sw_reset_req;
  logic [3:0] nt_stage_ack;
  logic [3:0] nt_stage_reset_n;
  logic       nt_seq_done;
  logic       nt_seq_error;
  logic [1:0] nt_err_stage;

  int n_checks;
  int n_errors;

  reset_sequencer #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(16),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk          (clk),
    .sync_reset   (sync_reset),
    .sw_reset_req (sw_reset_req),
    .stage_ack    (stage_ack),
    .stage_reset_n(stage_reset_n),
    .seq_done     (seq_done),
    .seq_error    (seq_error),
    .err_stage    (err_stage)
  );

  reset_sequencer #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(16),
    .ACK_TIMEOUT(0)
  ) dut_nt (
    .clk          (clk),
    .sync_reset   (nt_sync_reset),
    .sw_reset_req (nt_sw_reset_req),
    .stage_ack    (nt_stage_ack),
    .stage_reset_n(nt_stage_reset_n),
    .seq_done     (nt_seq_done),
    .seq_error    (nt_seq_error),
    .err_stage    (nt_err_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit before sampling.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] srn, input logic done,
                            input logic err, input logic [1:0] stg);
    check({tag, "_srn"}, 32'(stage_reset_n), 32'(srn));
    check({tag, "_done"}, 32'(seq_done), 32'(done));
    check({tag, "_err"}, 32'(seq_error), 32'(err));
    check({tag, "_stage"}, 32'(err_stage), 32'(stg));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks        = 0;
    n_errors        = 0;
    sync_reset      = 1'b1;
    sw_reset_req    = 1'b0;
    stage_ack       = 4'b1111;
    nt_sync_reset   = 1'b1;
    nt_sw_reset_req = 1'b0;
    nt_stage_ack    = 4'b0000;

    // 1: reset, then full release with all acks tied high.
    tick(3);
    check_outs("t1_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    sync_reset    = 1'b0;
    nt_sync_reset = 1'b0;
    tick(15);
    check_outs("t1_hold15", 4'b0000, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("t1_edge16", 4'b0001, 1'b0, 1'b0, 2'd0);
    tick();
    check("t1_edge17", 32'(stage_reset_n), 32'h3);
    tick();
    check("t1_edge18", 32'(stage_reset_n), 32'h7);
    tick();
    check_outs("t1_edge19", 4'b1111, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("t1_edge20", 4'b1111, 1'b1, 1'b0, 2'd0);
    stage_ack = 4'b0000;
    tick(3);
    check_outs("t1_done_hold", 4'b1111, 1'b1, 1'b0, 2'd0);

    // 4a: restart pulse from S_DONE.
    sw_reset_req = 1'b1;
    tick();
    check_outs("t4a_restart", 4'b0000, 1'b0, 1'b0, 2'd0);
    sw_reset_req = 1'b0;

    // 2: late ack on stage 1, early ack on stage 3 ignored.
    stage_ack = 4'b1001;
    tick(15);
    check("t2_hold15", 32'(stage_reset_n), 32'h0);
    tick();
    check("t2_edge16", 32'(stage_reset_n), 32'h1);
    tick();
    check("t2_rel1", 32'(stage_reset_n), 32'h3);
    tick(5);
    check_outs("t2_wait5", 4'b0011, 1'b0, 1'b0, 2'd0);
    stage_ack = 4'b1011;
    tick();
    check_outs("t2_ack1", 4'b0111, 1'b0, 1'b0, 2'd0);

    // 3: stage 2 never acks -> timeout on the 8th edge.
    tick(7);
    check_outs("t3_edge7", 4'b0111, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("t3_timeout", 4'b0000, 1'b0, 1'b1, 2'd2);
    for (int k = 0; k < 50; k++) begin
      tick();
      check("t3_held", {25'd0, seq_error, err_stage, stage_reset_n}, {25'd0, 1'b1, 2'd2, 4'b0000});
    end

    // 4b: restart pulse from S_ERROR, full sequence repeats.
    sw_reset_req = 1'b1;
    tick();
    check_outs("t4b_restart", 4'b0000, 1'b0, 1'b0, 2'd0);
    sw_reset_req = 1'b0;
    stage_ack    = 4'b1111;
    tick(15);
    check("t4b_hold15", 32'(stage_reset_n), 32'h0);
    tick();
    check("t4b_edge16", 32'(stage_reset_n), 32'h1);
    tick(3);
    check_outs("t4b_edge19", 4'b1111, 1'b0, 1'b0, 2'd0);
    tick();
    check_outs("t4b_edge20", 4'b1111, 1'b1, 1'b0, 2'd0);

    // 5: sync_reset together with sw_reset_req mid-sequence.
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    stage_ack    = 4'b0001;
    tick(17);
    check("t5_rel1", 32'(stage_reset_n), 32'h3);
    sync_reset   = 1'b1;
    sw_reset_req = 1'b1;
    tick();
    check_outs("t5_reset", 4'b0000, 1'b0, 1'b0, 2'd0);
    sync_reset   = 1'b0;
    sw_reset_req = 1'b0;
    stage_ack    = 4'b1111;
    tick(15);
    check("t5_hold15", 32'(stage_reset_n), 32'h0);
    tick();
    check("t5_edge16", 32'(stage_reset_n), 32'h1);
    tick(4);
    check_outs("t5_edge20", 4'b1111, 1'b1, 1'b0, 2'd0);

    // 6: ack arrives exactly on the timeout edge -> ack wins.
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    stage_ack    = 4'b0000;
    tick(16);
    check("t6_rel0", 32'(stage_reset_n), 32'h1);
    tick(7);
    check_outs("t6_edge7", 4'b0001, 1'b0, 1'b0, 2'd0);
    stage_ack = 4'b0001;
    tick();
    check_outs("t6_ack_on_timeout", 4'b0011, 1'b0, 1'b0, 2'd0);

    // 6b: timeout disabled, stage 0 never acks.
    tick(300);
    check("t6b_srn", 32'(nt_stage_reset_n), 32'h1);
    check("t6b_err", 32'(nt_seq_error), 32'h0);
    check("t6b_done", 32'(nt_seq_done), 32'h0);
    check("t6b_stage", 32'(nt_err_stage), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
